// File: rtl/cnt_disp_mux_pkg.sv
// ============================================================================
// Module      : cnt_disp_mux_pkg
// Description : Shared constants and helpers for the cascaded counter and its
//               multiplexed 7-segment display driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_disp_mux_pkg;

    // Active-low gfedcba patterns for hex digits 0..F
    localparam logic [6:0] c_seg_table [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [6:0] c_seg_blank = 7'b1111111;

    // Bits needed to index n items; never less than 1 so a single item still
    // gets a legal vector width.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex_dec.sv
// ============================================================================
// Module      : seg7_hex_dec
// Description : Combinational 4-bit to active-low 7-segment decoder; codes at
//               or above RADIX are shown blank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_dec
    import cnt_disp_mux_pkg::*;
#(
    parameter int RADIX = 16
) (
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    localparam logic [4:0] c_radix = 5'(RADIX);

    always_comb begin
        o_seg = c_seg_table[i_digit];
        if ({1'b0, i_digit} >= c_radix) begin
            o_seg = c_seg_blank;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cnt_disp_mux.sv
// ============================================================================
// Module      : cnt_disp_mux
// Description : N-digit cascaded up/down counter (decimal or hex) with a
//               time-multiplexed, registered 7-segment display driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_disp_mux
    import cnt_disp_mux_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int RADIX    = 16,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  CLR,
    output logic [4*DIGITS-1:0]   CNTVAL,
    output logic                  OV,
    output logic [6:0]            SEG,
    output logic [DIGITS-1:0]     DIG_EN
);

    localparam int                 c_idx_w     = idx_width(DIGITS);
    localparam int                 c_div_w     = idx_width(SCAN_DIV);
    localparam logic [3:0]         c_digit_max = 4'(RADIX - 1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DIGITS - 1);
    localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);
    localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_one   = c_div_w'(1);

    logic [3:0]          w_digit [DIGITS];
    logic [DIGITS:0]     w_lo_max;
    logic [DIGITS:0]     w_lo_zero;
    logic [c_div_w-1:0]  r_div;
    logic [c_idx_w-1:0]  r_idx;
    logic [3:0]          w_cur_digit;
    logic [6:0]          w_seg;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_dig_en;

    // w_lo_max[i] / w_lo_zero[i]: every digit below i sits at its terminal
    // value, so digit i takes a step this cycle.
    assign w_lo_max[0]  = 1'b1;
    assign w_lo_zero[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] r_digit;

            assign w_lo_max[gi+1]  = w_lo_max[gi]  & (r_digit == c_digit_max);
            assign w_lo_zero[gi+1] = w_lo_zero[gi] & (r_digit == 4'd0);

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_digit <= 4'd0;
                end else if (CLR) begin
                    r_digit <= 4'd0;
                end else if (EN) begin
                    if (UP) begin
                        if (w_lo_max[gi]) begin
                            r_digit <= (r_digit == c_digit_max) ? 4'd0 : r_digit + 4'd1;
                        end
                    end else if (w_lo_zero[gi]) begin
                        r_digit <= (r_digit == 4'd0) ? c_digit_max : r_digit - 4'd1;
                    end
                end
            end

            assign w_digit[gi]        = r_digit;
            assign CNTVAL[4*gi +: 4]  = r_digit;
        end
    endgenerate

    assign OV = EN & ~CLR & (UP ? w_lo_max[DIGITS] : w_lo_zero[DIGITS]);

    // Scan timing free-runs; counting and clearing never disturb it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == c_div_last) begin
            r_div <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_one;
        end else begin
            r_div <= r_div + c_div_one;
        end
    end

    assign w_cur_digit = w_digit[r_idx];

    seg7_hex_dec #(
        .RADIX   (RADIX)
    ) u_dec (
        .i_digit (w_cur_digit),
        .o_seg   (w_seg)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_seg    <= c_seg_blank;
            r_dig_en <= '0;
        end else begin
            r_seg    <= w_seg;
            r_dig_en <= DIGITS'(1) << r_idx;
        end
    end

    assign SEG    = r_seg;
    assign DIG_EN = r_dig_en;

endmodule

`default_nettype wire

// File: doc/cnt_disp_mux.md
Name: cnt_disp_mux

Overview:
Parametrised multi-digit cascaded counter with a time-multiplexed 7-segment display driver. It generalises the single-digit enabled hex counter with segment decode to the following features:
- N digits, selectable radix (decimal or hex)
- up/down counting and synchronous clear
- asynchronous active-low reset
- scanned digit output for a shared-segment display

It sits between a tick/enable source and the board's segment/digit pins.

Parameters:
DIGITS, 4, number of cascaded digits (1..8)
RADIX, 16, per-digit modulus; only 10 or 16 legal
SCAN_DIV, 1000, clock cycles each digit is displayed (>=2)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  reset, asynchronous assert, active-low
EN  input  1  count enable; one step per cycle while high
UP  input  1  1 = count up, 0 = count down
CLR  input  1  synchronous clear of all digits
CNTVAL  output  4*DIGITS  packed digit values; digit 0 (least significant) in bits [3:0]
OV  output  1  terminal-count carry/borrow out, combinational
SEG  output  7  segment pattern gfedcba, active-low
DIG_EN  output  DIGITS  one-hot digit select, active-high

Behaviour:
- Reset (RST_N=0, async):
  - CNTVAL=0, scan divider=0, scan index=0
  - SEG=7'b1111111 (blank), DIG_EN=0
- Clear: CLR=1 sets CNTVAL=0 on the next edge. It has priority over EN and UP. It does not affect the scan logic.
- Counting: applies when EN=1 and CLR=0. EN=0 holds the value.
- Up counting (UP=1):
  - digit 0 increments every enabled cycle
  - digit i increments only when all lower digits equal RADIX-1
  - a digit at RADIX-1 that increments wraps to 0
- Down counting (UP=0):
  - digit i decrements only when all lower digits equal 0
  - a digit at 0 that decrements wraps to RADIX-1
- Full wrap: all digits at RADIX-1 going up gives all 0; all 0 going down gives all RADIX-1.
- OV = EN & ~CLR & (UP ? all digits==RADIX-1 : all digits==0). It is high in the cycle before the wrap edge so counters can be cascaded.
- Digit values never exceed RADIX-1. In RADIX=10, codes 10..15 are unreachable. If seen at the decoder, they display blank.
- UP may change any cycle. Direction takes effect on the next enabled edge with no extra latency.
- Scan divider:
  - counts 0..SCAN_DIV-1, then wraps
  - at the terminal value the scan index advances 0..DIGITS-1, then wraps to 0
  - free-runs independently of EN and CLR
- Display outputs are registered, updated every cycle:
  - DIG_EN = 1<<index
  - SEG = decode(digit[index])
  - latency is one cycle from an index or value change to the pins
  - first valid display is on the first edge after reset release
- Decode table (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-count or mid-scan: all state returns to reset values immediately (asynchronous). Counting resumes from 0 on the first edge after release.
- DIGITS=1: the scan index is fixed at 0 and DIG_EN stays 1 after reset.

Decomposition:
- Shared package holds:
  - the 16-entry segment table constant and the blank pattern
  - an index-width function (clog2) used for the scan index and divider widths
- One natural sub-module, seg7_hex_dec: a combinational 4-bit-to-7-segment decoder instantiated once after the index mux.
- The digit cascade is a generate loop in the top level.

Test Plan:
1. Reset release with DIGITS=4, RADIX=16 -> CNTVAL=16'h0000, DIG_EN=4'b0000, SEG=7'b1111111 during reset; one edge after release DIG_EN=4'b0001, SEG=7'b1000000.
2. RADIX=10, UP=1, EN=1 from 0 for 1000 cycles -> CNTVAL=16'h1000. OV is high exactly in the cycle where CNTVAL=16'h9999, and the next value is 16'h0000.
3. RADIX=16, UP=0, EN=1 from 0 -> next CNTVAL=16'hFFFF with OV=1 in the prior cycle. Pulsing EN low for 3 cycles holds the value.
4. CNTVAL=16'h0123, CLR=1 and EN=1 simultaneously -> next CNTVAL=16'h0000. The scan index keeps advancing unaffected.
5. SCAN_DIV=4, CNTVAL=16'h4A70 held -> DIG_EN rotates 0001,0010,0100,1000 every 4 cycles. SEG follows 1000000 (0), 1111000 (7), 0001000 (A), 0011001 (4).
6. RST_N asserted mid-scan at index 2 with CNTVAL=16'h0055 -> outputs return to reset values without a clock edge. After release, counting resumes from 16'h0000 and scanning from digit 0.
